// File: rtl/regfile_param_bist.sv
// Parametrised 2-read/1-write register file with optional hardwired zero register,
// optional write-to-read bypass, synchronous clear and a march-style BIST engine.
module regfile_param_bist #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [ADDR_BITS-1:0] ReadRegister1,
    input  logic [ADDR_BITS-1:0] ReadRegister2,
    output logic [WIDTH-1:0]     ReadData1,
    output logic [WIDTH-1:0]     ReadData2,
    input  logic [ADDR_BITS-1:0] WriteRegister,
    input  logic [WIDTH-1:0]     WriteData,
    input  logic                 RegWrite,
    input  logic                 BistStart,
    output logic                 BistBusy,
    output logic                 BistDone,
    output logic                 BistPass,
    output logic [ADDR_BITS-1:0] BistFailAddr,
    output logic [2:0]           bist_state
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BP    = (BYPASS != 0);
    localparam logic [ADDR_BITS-1:0] ADDR_MAX = '1;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] W0   = 3'd1;
    localparam logic [2:0] R0W1 = 3'd2;
    localparam logic [2:0] R1W0 = 3'd3;
    localparam logic [2:0] R0   = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [2:0]           state;
    logic [ADDR_BITS-1:0] addr;
    logic                 busy, host_we, bist_we, check, mismatch, last;
    logic                 done_q, pass_q;
    logic [ADDR_BITS-1:0] fail_q;
    logic [WIDTH-1:0]     bist_rd, bist_exp, bist_wd;

    assign busy    = state inside {W0, R0W1, R1W0, R0};
    assign host_we = RegWrite && !busy && !(ZR && WriteRegister == '0);
    assign bist_rd = (ZR && addr == '0) ? '0 : mem[addr];

    // Per-phase march operation; address 0 always expects zero when it is hardwired.
    always_comb begin
        bist_we  = 1'b0;
        bist_wd  = '0;
        bist_exp = '0;
        check    = 1'b0;
        case (state)
            W0: bist_we = 1'b1;
            R0W1: begin
                check   = 1'b1;
                bist_we = 1'b1;
                bist_wd = '1;
            end
            R1W0: begin
                check    = 1'b1;
                bist_we  = 1'b1;
                bist_exp = (ZR && addr == '0) ? '0 : '1;
            end
            R0: check = 1'b1;
            default: ;
        endcase
    end

    assign mismatch = check && (bist_rd != bist_exp);
    assign last     = (state == R1W0) ? (addr == '0) : (addr == ADDR_MAX);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            addr   <= '0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            fail_q <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (BistStart) begin
                        state  <= W0;
                        addr   <= '0;
                        done_q <= 1'b0;
                        pass_q <= 1'b0;
                        fail_q <= '0;
                    end
                end
                W0, R0W1, R1W0, R0: begin
                    if (mismatch) begin
                        fail_q <= addr;
                        pass_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else if (last) begin
                        case (state)
                            W0:      begin state <= R0W1; addr <= '0;       end
                            R0W1:    begin state <= R1W0; addr <= ADDR_MAX; end
                            R1W0:    begin state <= R0;   addr <= '0;       end
                            default: begin
                                state  <= DONE;
                                done_q <= 1'b1;
                                pass_q <= 1'b1;
                            end
                        endcase
                    end else if (state == R1W0) begin
                        addr <= addr - 1'b1;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // BIST owns the write port while busy, so host writes are dropped then.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bist_we) begin
            if (!(ZR && addr == '0)) mem[addr] <= bist_wd;
        end else if (host_we) begin
            mem[WriteRegister] <= WriteData;
        end
    end

    always_comb begin
        if (BP && host_we && WriteRegister == ReadRegister1) ReadData1 = WriteData;
        else if (ZR && ReadRegister1 == '0)                  ReadData1 = '0;
        else                                                 ReadData1 = mem[ReadRegister1];
    end

    always_comb begin
        if (BP && host_we && WriteRegister == ReadRegister2) ReadData2 = WriteData;
        else if (ZR && ReadRegister2 == '0)                  ReadData2 = '0;
        else                                                 ReadData2 = mem[ReadRegister2];
    end

    assign BistBusy     = busy;
    assign BistDone     = done_q;
    assign BistPass     = pass_q;
    assign BistFailAddr = fail_q;
    assign bist_state   = state;

endmodule

// File: tb/tb_regfile_param_bist.sv
// Bench for regfile_param_bist: three configurations (default, no zero register,
// bypass) share one stimulus stream and are checked against an array model.
module tb_regfile_param_bist;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [4:0]  rr1 = '0, rr2 = '0, wr = '0;
    logic [31:0] wd = '0;
    logic        we = 1'b0, start = 1'b0;

    logic [2:0][31:0] rd1, rd2;
    logic [2:0]       busy, done, pass;
    logic [2:0][4:0]  fa;
    logic [2:0][2:0]  st;

    always #5 Clk = ~Clk;

    regfile_param_bist u_z (
        .Clk(Clk), .Reset(Reset), .ReadRegister1(rr1), .ReadRegister2(rr2),
        .ReadData1(rd1[0]), .ReadData2(rd2[0]), .WriteRegister(wr), .WriteData(wd),
        .RegWrite(we), .BistStart(start), .BistBusy(busy[0]), .BistDone(done[0]),
        .BistPass(pass[0]), .BistFailAddr(fa[0]), .bist_state(st[0]));

    regfile_param_bist #(.ZERO_REG(0)) u_nz (
        .Clk(Clk), .Reset(Reset), .ReadRegister1(rr1), .ReadRegister2(rr2),
        .ReadData1(rd1[1]), .ReadData2(rd2[1]), .WriteRegister(wr), .WriteData(wd),
        .RegWrite(we), .BistStart(start), .BistBusy(busy[1]), .BistDone(done[1]),
        .BistPass(pass[1]), .BistFailAddr(fa[1]), .bist_state(st[1]));

    regfile_param_bist #(.BYPASS(1)) u_bp (
        .Clk(Clk), .Reset(Reset), .ReadRegister1(rr1), .ReadRegister2(rr2),
        .ReadData1(rd1[2]), .ReadData2(rd2[2]), .WriteRegister(wr), .WriteData(wd),
        .RegWrite(we), .BistStart(start), .BistBusy(busy[2]), .BistDone(done[2]),
        .BistPass(pass[2]), .BistFailAddr(fa[2]), .bist_state(st[2]));

    int          n_cmp = 0;
    int          n_err = 0;
    bit          in_bist = 1'b0;
    logic [31:0] m_z  [32];
    logic [31:0] m_nz [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin
            m_z[i]  = '0;
            m_nz[i] = '0;
        end
    endtask

    // k: 0 = zero register, 1 = plain array, 2 = zero register with bypass
    function automatic logic [31:0] exp_rd(input int k, input logic [4:0] ra);
        if (k == 1) return m_nz[ra];
        if (k == 2 && we && !in_bist && wr == ra && wr != 5'd0) return wd;
        return (ra == 5'd0) ? 32'd0 : m_z[ra];
    endfunction

    task automatic check_reads();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rd1_cfg%0d_a%0d", k, rr1), rd1[k], exp_rd(k, rr1));
            chk($sformatf("rd2_cfg%0d_a%0d", k, rr2), rd2[k], exp_rd(k, rr2));
        end
    endtask

    task automatic chk_flags(input string tag, input logic b, input logic d, input logic p);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_busy%0d", tag, k), 32'(busy[k]), 32'(b));
            chk($sformatf("%s_done%0d", tag, k), 32'(done[k]), 32'(d));
            chk($sformatf("%s_pass%0d", tag, k), 32'(pass[k]), 32'(p));
            chk($sformatf("%s_faddr%0d", tag, k), 32'(fa[k]), 32'd0);
        end
    endtask

    task automatic edge_commit();
        @(posedge Clk);
        if (Reset) clear_model();
        else if (we && !in_bist) begin
            if (wr != 5'd0) m_z[wr] = wd;
            m_nz[wr] = wd;
        end
        #1;
    endtask

    task automatic cycle();
        @(negedge Clk);
        if (!in_bist) check_reads();
        edge_commit();
    endtask

    task automatic sweep();
        we = 1'b0;
        start = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rr1 = 5'(a);
            rr2 = 5'(31 - a);
            cycle();
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1;
        wr = a;
        wd = d;
        cycle();
        we = 1'b0;
    endtask

    task automatic run_bist(input int reset_at, output int cnt);
        bit stop;
        cnt  = 0;
        stop = 1'b0;
        we    = 1'b1;
        wr    = 5'($urandom_range(1, 31));
        wd    = $urandom;
        start = 1'b1;
        cycle();
        start   = 1'b0;
        in_bist = 1'b1;
        while (!stop) begin
            @(negedge Clk);
            if (!busy[0]) begin
                stop = 1'b1;
            end else begin
                cnt++;
                for (int k = 1; k < 3; k++) chk($sformatf("bist_busy%0d_c%0d", k, cnt), 32'(busy[k]), 32'd1);
                we    = 1'($urandom_range(0, 1));
                wr    = 5'($urandom);
                wd    = $urandom;
                rr1   = 5'($urandom);
                start = (cnt == 60);
                Reset = (cnt == reset_at);
                @(posedge Clk);
                #1;
                if (Reset) begin
                    Reset = 1'b0;
                    stop  = 1'b1;
                end
                if (cnt >= 2000) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL bist_timeout observed=%0d expected=%0d", cnt, 128);
                    stop = 1'b1;
                end
            end
        end
        we      = 1'b0;
        start   = 1'b0;
        in_bist = 1'b0;
        clear_model();
    endtask

    initial begin
        int cnt;
        clear_model();

        // 1: one-cycle reset, then every address reads zero and flags are clear
        edge_commit();
        Reset = 1'b0;
        @(negedge Clk);
        chk_flags("reset", 1'b0, 1'b0, 1'b0);
        edge_commit();
        sweep();

        // 2: directed writes and a disabled write
        write_reg(5'd2, 32'd42);
        write_reg(5'd16, 32'd15);
        write_reg(5'd31, 32'd15);
        write_reg(5'd16, 32'd31);
        rr1 = 5'd16;
        rr2 = 5'd31;
        @(negedge Clk);
        chk("p1_r16", rd1[0], 32'd31);
        chk("p2_r31", rd2[0], 32'd15);
        edge_commit();
        rr1 = 5'd2;
        we  = 1'b0;
        wr  = 5'd2;
        wd  = 32'd30;
        cycle();
        @(negedge Clk);
        chk("p1_r2_after_we0", rd1[0], 32'd42);
        edge_commit();

        // 3: write to register 0
        write_reg(5'd0, 32'd15);
        rr1 = 5'd0;
        rr2 = 5'd0;
        @(negedge Clk);
        chk("zero_p1", rd1[0], 32'd0);
        chk("zero_p2", rd2[0], 32'd0);
        chk("nozero_p1", rd1[1], 32'd15);
        chk("nozero_p2", rd2[1], 32'd15);
        edge_commit();

        // 4: same-cycle bypass versus registered read
        rr1 = 5'd5;
        we  = 1'b1;
        wr  = 5'd5;
        wd  = 32'hDEADBEEF;
        @(negedge Clk);
        chk("bypass_p1", rd1[2], 32'hDEADBEEF);
        chk("nobypass_p1", rd1[0], 32'd0);
        edge_commit();
        we = 1'b0;
        @(negedge Clk);
        chk("after_edge_p1", rd1[0], 32'hDEADBEEF);
        edge_commit();

        // random traffic, often reading the address being written
        for (int i = 0; i < 200; i++) begin
            we  = 1'($urandom_range(0, 1));
            wr  = 5'($urandom);
            wd  = $urandom;
            rr1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom);
            rr2 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom);
            cycle();
        end

        // 5: clean BIST run over preloaded data, with host writes and restart attempts while busy
        write_reg(5'd3, 32'hA5A5_0003);
        write_reg(5'd9, 32'h1234_5679);
        run_bist(-1, cnt);
        chk("bist_busy_cycles", 32'(cnt), 32'd128);
        chk_flags("bist_end", 1'b0, 1'b1, 1'b1);
        sweep();

        // 6: reset in the middle of a run, then a fresh run
        write_reg(5'd7, 32'h0000_0777);
        run_bist(40, cnt);
        chk("bist_reset_cycle", 32'(cnt), 32'd40);
        @(negedge Clk);
        chk_flags("mid_reset", 1'b0, 1'b0, 1'b0);
        edge_commit();
        sweep();
        run_bist(-1, cnt);
        chk("bist2_busy_cycles", 32'(cnt), 32'd128);
        chk_flags("bist2_end", 1'b0, 1'b1, 1'b1);
        sweep();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regfile_param_bist.md
Name: regfile_param_bist

Overview:
- Parametrised multi-port register file: WIDTH-bit words, 2**ADDR_BITS entries, two asynchronous read ports, one synchronous write port.
- Generalises the fixed 32x32 CPU register file with three additions: configurable hardwired-zero register 0, optional write-to-read bypass, and a synchronous reset that clears the array.
- Integrated march-style built-in self-test (BIST) engine lets the datapath check the array in silicon.
- Sits in the CPU datapath in place of the fixed register file.

Parameters:
- WIDTH, 32, data word width in bits.
- ADDR_BITS, 5, address width; DEPTH = 2**ADDR_BITS entries.
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes.
- BYPASS, 0, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- Clk  input  1  clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- ReadRegister1  input  ADDR_BITS  read port 1 address.
- ReadRegister2  input  ADDR_BITS  read port 2 address.
- ReadData1  output  WIDTH  read port 1 data.
- ReadData2  output  WIDTH  read port 2 data.
- WriteRegister  input  ADDR_BITS  write address.
- WriteData  input  WIDTH  write data.
- RegWrite  input  1  write enable, active high.
- BistStart  input  1  single-cycle request to run BIST.
- BistBusy  output  1  high while BIST owns the array.
- BistDone  output  1  sticky, high after BIST ends.
- BistPass  output  1  valid when BistDone=1; 1 means no mismatch.
- BistFailAddr  output  ADDR_BITS  address of first mismatch; 0 if none.

Behaviour:
- Reset (sampled at rising edge of Clk):
  - All DEPTH entries cleared to 0.
  - BistBusy=0, BistDone=0, BistPass=0, BistFailAddr=0.
  - FSM goes to IDLE.
  - Reset wins over every other input, including mid-BIST.
- Reads:
  - Combinational: ReadDataN = array[ReadRegisterN].
  - When ZERO_REG=1 and ReadRegisterN=0, ReadDataN=0.
  - Reads stay functional during BIST and return live array contents.
- Writes:
  - At rising edge, if RegWrite=1 and BistBusy=0, array[WriteRegister] <= WriteData.
  - Writes to address 0 are dropped when ZERO_REG=1.
  - RegWrite=0 never modifies any entry.
  - Exactly one entry changes per write; no other address is disturbed.
- Bypass:
  - Applies when BYPASS=1, RegWrite=1, BistBusy=0, WriteRegister=ReadRegisterN, and the write is not to a ZERO_REG-protected address 0.
  - Under those conditions ReadDataN=WriteData in the same cycle, before the edge.
  - With BYPASS=0, reads return the old value until after the edge.
- BIST FSM states: IDLE, W0, R0W1, R1W0, R0, DONE.
  - IDLE -> W0 on BistStart=1. BistBusy goes high on the next cycle. BistDone and BistPass clear on entry to W0.
  - W0: ascending addresses 0..DEPTH-1, one per cycle; write all-zeros.
  - R0W1: ascending; compare entry to 0, then write all-ones in the same cycle.
  - R1W0: descending DEPTH-1..0; compare to all-ones, then write 0.
  - R0: ascending; compare to 0, no write.
  - Expected value at address 0 is 0 in every phase when ZERO_REG=1.
  - Each phase takes DEPTH cycles, so a clean run keeps BistBusy high for exactly 4*DEPTH cycles.
  - Clean run ends in DONE with BistDone=1, BistPass=1, BistFailAddr=0, and every entry 0.
  - First mismatch: BistFailAddr latches the address, BistPass=0, and the FSM moves to DONE the next cycle (abort).
  - DONE -> W0 on a new BistStart; otherwise DONE holds its flags.
- Simultaneous and boundary cases:
  - BistStart while busy: ignored.
  - RegWrite while busy: ignored; no bypass.
  - BistStart and RegWrite in the same IDLE/DONE cycle: the write commits, then BIST starts.
  - Address counter wraps cleanly at DEPTH-1 and at 0; no out-of-range access.

Test Plan:
1. Reset for 1 cycle, sweep all 32 addresses on both ports -> every read 0; Bist flags all 0.
2. Write 42 to reg 2, 15 to reg 16, 15 to reg 31, 31 to reg 16 -> port1(16)=31, port2(31)=15, port1(2)=42. Then RegWrite=0 with reg 2 / 30 -> reg 2 still 42.
3. Write 15 to reg 0 with ZERO_REG=1 -> both ports read 0. With ZERO_REG=0 -> both read 15.
4. BYPASS=1: RegWrite=1, reg 5, 0xDEADBEEF, ReadRegister1=5 -> ReadData1=0xDEADBEEF before the edge. BYPASS=0 -> prior value (0) until after the edge.
5. Preload regs 3/9 with nonzero data, pulse BistStart -> BistBusy high exactly 128 cycles, then BistDone=1, BistPass=1, BistFailAddr=0, all entries 0. RegWrite asserted during busy has no effect.
6. Assert Reset at busy cycle 40 of a BIST run -> next cycle BistBusy=0, BistDone=0, BistPass=0, all entries 0. A fresh BistStart then completes with BistPass=1.
